// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; mid-bit sampling off a divided tick.
// Emits one-cycle rx_valid / frame_err pulses after the mid-stop sample.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line idle, waiting for a 1->0 edge on the synchronized line
// ST_START | timing to mid start bit to confirm it is still low
// ST_DATA  | sampling 8 data bits at their centres, LSB first
// ST_STOP  | sampling the stop bit at its centre
module uart_rx #(
    parameter logic [15:0] CLKDIV = 16'd27
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_rxd_prev;
    logic [15:0] r_div_cnt;
    logic [3:0]  r_s_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_frame_err;

    logic        w_rxd_s;
    logic        w_start_edge;
    logic        w_tick;
    logic        w_cnt_clr;
    logic        w_s_clr;
    logic        w_shift;
    logic        w_load;
    logic        w_ferr;

    assign w_rxd_s      = r_sync2;
    assign w_start_edge = r_rxd_prev & ~w_rxd_s;
    assign w_tick       = (r_div_cnt == CLKDIV - 16'd1);

    // Synchronizer and edge history idle high so reset release never looks like a start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd;
            r_sync2    <= r_sync1;
            r_rxd_prev <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_s_clr     = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tick && (r_s_cnt == 4'd7)) begin
                    if (!w_rxd_s) begin
                        w_s_clr     = 1'b1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick && (r_s_cnt == 4'd15)) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick && (r_s_cnt == 4'd15)) begin
                    w_load      = w_rxd_s;
                    w_ferr      = ~w_rxd_s;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Divider and sample counter free-run; only the start edge realigns them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_div_cnt <= 16'd0;
            r_s_cnt   <= 4'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else if (w_cnt_clr) begin
            r_div_cnt <= 16'd0;
            r_s_cnt   <= 4'd0;
            r_bit_cnt <= 3'd0;
        end else begin
            r_div_cnt <= w_tick ? 16'd0 : r_div_cnt + 16'd1;
            if (w_s_clr) begin
                r_s_cnt <= 4'd0;
            end else if (w_tick) begin
                r_s_cnt <= r_s_cnt + 4'd1;
            end
            if (w_shift) begin
                r_shift   <= {w_rxd_s, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_load;
            r_frame_err <= w_ferr;
            if (w_load) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKDIV=4 (64 clocks per bit): frames are
// modelled as byte + stop level, expected pulses are queued and a monitor checks them.
module tb_uart_rx;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_rx #(.CLKDIV(16'd4)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_last = 8'h00;
    int         n_checks = 0;
    int         n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Good frame: rx_valid with the byte. Bad stop: frame_err, rx_data keeps last good byte.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
        exp_t e;
        if (stop) model_last = b;
        e.err  = ~stop;
        e.data = model_last;
        exp_q.push_back(e);
        drive(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(b[i], bclk);
        drive(stop, bclk);
    endtask

    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    always @(negedge clk) begin
        if (!n_rst) begin
            prev_v = 1'b0;
            prev_e = 1'b0;
        end else begin
            if (rx_valid || frame_err) begin
                chk("pulse_exclusive", int'(rx_valid & frame_err), 0);
                chk("pulse_width", int'((rx_valid & prev_v) | (frame_err & prev_e)), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%02h expected no pulse",
                             rx_valid, frame_err, rx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_is_frame_err", int'(frame_err), int'(e.err));
                    chk("rx_data", int'(rx_data), int'(e.data));
                end
            end
            prev_v = rx_valid;
            prev_e = frame_err;
        end
    end

    initial begin
        int         seen;
        int         clear_at;
        int         busy_cnt;
        logic [7:0] b;
        logic       stop;
        int         bclk;

        n_rst = 1'b0;
        rxd   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_rx_busy", int'(rx_busy), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        drive(1'b1, 20);
        chk("release_no_start", int'(rx_busy), 0);

        send_frame(8'hA5, 1'b1, BIT);
        drive(1'b1, 20);

        send_frame(8'h3C, 1'b1, BIT);
        send_frame(8'hC3, 1'b1, BIT);
        drive(1'b1, 20);

        seen     = 0;
        clear_at = -1;
        rxd      = 1'b0;
        for (int k = 0; k < 48; k++) begin
            if (k == 16) rxd = 1'b1;
            @(negedge clk);
            if (rx_busy) seen = 1;
            if (seen != 0 && !rx_busy && clear_at < 0) clear_at = k;
            @(posedge clk);
            #1;
        end
        chk("glitch_busy_seen", seen, 1);
        chk("glitch_busy_cleared_in_time", int'(clear_at >= 0 && clear_at <= 36), 1);
        drive(1'b1, 20);

        send_frame(8'h55, 1'b0, BIT);
        busy_cnt = 0;
        for (int k = 0; k < 3 * BIT; k++) begin
            @(negedge clk);
            if (rx_busy) busy_cnt++;
            @(posedge clk);
            #1;
        end
        chk("break_no_restart", busy_cnt, 0);
        drive(1'b1, 10);

        b = 8'hFF;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(b[i], BIT);
        drive(b[4], BIT / 2);
        @(negedge clk);
        chk("abort_busy_before_reset", int'(rx_busy), 1);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        model_last = 8'h00;
        drive(1'b1, 4);
        @(negedge clk);
        chk("midframe_reset_busy", int'(rx_busy), 0);
        chk("midframe_reset_rx_data", int'(rx_data), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        drive(1'b1, 3 * BIT);
        chk("post_abort_idle", int'(rx_busy), 0);
        send_frame(8'h12, 1'b1, BIT);
        drive(1'b1, 10);

        send_frame(8'h00, 1'b1, 62);
        drive(1'b1, 10);
        send_frame(8'hFF, 1'b1, 62);
        drive(1'b1, 10);
        send_frame(8'h00, 1'b1, 66);
        drive(1'b1, 10);
        send_frame(8'hFF, 1'b1, 66);
        drive(1'b1, 10);

        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       bclk = 62;
                1:       bclk = 64;
                default: bclk = 66;
            endcase
            send_frame(b, stop, bclk);
            if (stop) drive(1'b1, $urandom_range(0, 8));
            else      drive(1'b1, $urandom_range(4, 12));
        end

        rxd = 1'b1;
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (20) @(posedge clk);
        chk("all_expected_pulses_seen", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKDIV, default 16'd27, the system clocks per 1/16-bit sample tick (50 MHz, 115200 baud, 16x oversampling).
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on the rising edge.
REQ-003 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port rx_data  output  8  last correctly framed byte, LSB received first.
REQ-006 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated in the same cycle.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse on a low stop bit.
REQ-008 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL pass rxd through a 2-flop synchronizer (reset value 1) to give rxd_s; all decisions SHALL use rxd_s only.
REQ-010 SHALL detect a start edge as previous rxd_s=1 and current rxd_s=0; a line that stays low SHALL NOT re-trigger.
REQ-011 SHALL have a divider counter div_cnt of 0..CLKDIV-1 that asserts tick for one cycle when div_cnt=CLKDIV-1 and then wraps to 0.
REQ-012 SHALL have a sample counter s_cnt of 0..15 that increments on tick and wraps 15->0.
REQ-013 SHALL have the states IDLE, START, DATA and STOP, encoded in 2 bits.
REQ-014 IDLE: on a start edge, SHALL clear div_cnt, s_cnt and the bit counter and go to START; otherwise SHALL stay in IDLE.
REQ-015 START: on a tick with s_cnt=7 (mid start bit), SHALL go to DATA with s_cnt cleared if rxd_s=0, or return to IDLE with no output pulse if rxd_s=1 (glitch rejected).
REQ-016 DATA: on each tick with s_cnt=15, SHALL shift rxd_s into bit 7 of an 8-bit shift register (shifting right) and increment bit_cnt (0..7); after the sample at bit_cnt=7, SHALL go to STOP.
REQ-017 STOP: on a tick with s_cnt=15, SHALL sample rxd_s and go to IDLE.
REQ-018 STOP sample =1: SHALL load rx_data from the shift register and pulse rx_valid in the next clock.
REQ-019 STOP sample =0: SHALL pulse frame_err in the next clock and leave rx_data unchanged.
REQ-020 Latency: the rx_valid pulse SHALL occur about 9.5 bit periods after the start edge reaches rxd_s, with a bit period of 16*CLKDIV clocks.
REQ-021 Back-to-back: because the receiver returns to IDLE at mid-stop, a start edge half a bit later SHALL be accepted.
REQ-022 Break or frame error: a line still low after the STOP sample SHALL NOT start a frame until rxd_s has been high for at least one clock.
REQ-023 rx_valid and frame_err SHALL never be high in the same cycle, and neither SHALL stay high for more than one cycle.
REQ-024 rxd activity in START, DATA or STOP SHALL NOT restart the frame; only the scheduled samples SHALL matter.
REQ-025 rx_data SHALL hold its value between rx_valid pulses.

Reset
REQ-026 While n_rst=0, SHALL force state=IDLE, div_cnt=0, s_cnt=0, bit_cnt=0, shift register=8'h00, rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0, and both synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a pulse; after release, the receiver SHALL wait in IDLE for a new start edge.
REQ-028 Reset release SHALL NOT produce a start edge when rxd is high.

Verification (CLKDIV=4, bit period 64 clocks)
REQ-029 Send 8'hA5 with a high stop bit -> a single rx_valid pulse, rx_data=8'hA5, frame_err stays 0.
REQ-030 Send 8'h3C then 8'hC3 back-to-back with one stop bit each -> two rx_valid pulses, rx_data=8'h3C then 8'hC3.
REQ-031 Low glitch of 16 clocks on an idle line -> no pulse, and rx_busy returns to 0 within 32 clocks of the edge.
REQ-032 Send 8'h55 with a low stop bit, then hold rxd low for 3 bit periods -> one frame_err pulse, rx_data keeps its prior value, and no further frame starts until rxd goes high.
REQ-033 Assert n_rst during bit 4 of 8'hFF, release it, then send 8'h12 -> no pulse for the aborted frame, then rx_valid with rx_data=8'h12.
REQ-034 Send 8'h00 and 8'hFF at a ±3% baud offset -> both bytes received correctly.
